// File: rtl/hier_arb_pkg.sv
// Shared definitions for the hierarchical round-robin arbiter: default
// parameter values, the per-edge action encoding and a width helper.
package hier_arb_pkg;

  localparam int DEF_NUM_GROUPS = 2;
  localparam int DEF_GROUP_SIZE = 2;
  localparam int DEF_MAX_HOLD   = 8;

  // What the grant register does at the coming edge.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_GRANT = 2'd2
  } arb_action_e;

  // $clog2 with a floor of 1 so single-entry indices still get a real bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/group_fixed_priority.sv
// Combinational lowest-index-first priority encoder for one requester group.
module group_fixed_priority
  import hier_arb_pkg::*;
#(
  parameter int GROUP_SIZE = DEF_GROUP_SIZE
) (
  input  logic [GROUP_SIZE-1:0]             req,
  output logic                              any_req,
  output logic [clog2_min1(GROUP_SIZE)-1:0] local_idx
);

  localparam int LW = clog2_min1(GROUP_SIZE);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any_req   = |req;
    local_idx = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (req[i]) local_idx = LW'(i);
    end
  end

endmodule

// File: rtl/hier_rr_arbiter.sv
// Two-level arbiter: fixed priority inside a group, round-robin between
// groups, registered grant locked to its holder until the holder drops req.
// Optional feature macro ARB_TIMEOUT_EN bounds the lock to MAX_HOLD cycles
// whenever another requester is waiting.
module hier_rr_arbiter
  import hier_arb_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int GROUP_SIZE = DEF_GROUP_SIZE
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
`endif
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_GROUPS*GROUP_SIZE-1:0]             req,
  output logic [NUM_GROUPS*GROUP_SIZE-1:0]             grant,
  output logic                                         grant_valid,
  output logic [clog2_min1(NUM_GROUPS*GROUP_SIZE)-1:0] grant_idx,
  output logic [clog2_min1(NUM_GROUPS)-1:0]            grant_group
);

  localparam int N  = NUM_GROUPS * GROUP_SIZE;
  localparam int IW = clog2_min1(N);
  localparam int GW = clog2_min1(NUM_GROUPS);
  localparam int LW = clog2_min1(GROUP_SIZE);

  logic [GW-1:0] rr_ptr;

  logic [N-1:0]  req_eff_p0;
  logic          hold_p0;
  logic          expire_p0;
  logic          grp_any_p0  [NUM_GROUPS];
  logic [LW-1:0] grp_lidx_p0 [NUM_GROUPS];
  logic [GW-1:0] win_group_p0;
  logic [IW-1:0] win_idx_p0;
  logic [N-1:0]  win_onehot_p0;
  logic [GW-1:0] next_ptr_p0;
  arb_action_e   action_p0;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = clog2_min1(MAX_HOLD);
  logic [HW-1:0] hold_cnt;
  logic          others_p0;

  // Holder's lock expires once it has held MAX_HOLD cycles and someone waits;
  // its own bit is then hidden from the fresh arbitration.
  always_comb begin
    others_p0  = |(req & ~grant);
    expire_p0  = hold_p0 && (hold_cnt == HW'(MAX_HOLD - 1)) && others_p0;
    req_eff_p0 = expire_p0 ? (req & ~grant) : req;
  end
`else
  // Without the timeout the lock is unbounded and arbitration sees raw req.
  always_comb begin
    expire_p0  = 1'b0;
    req_eff_p0 = req;
  end
`endif

  // Holder keeps the grant while its own request bit stays high.
  always_comb begin
    hold_p0 = grant_valid && req[grant_idx];
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    group_fixed_priority #(
      .GROUP_SIZE (GROUP_SIZE)
    ) u_grp (
      .req       (req_eff_p0[g*GROUP_SIZE +: GROUP_SIZE]),
      .any_req   (grp_any_p0[g]),
      .local_idx (grp_lidx_p0[g])
    );
  end

  // Pick the first requesting group at or after the rr pointer, then build
  // the flat index, one-hot vector and the pointer value past the winner.
  always_comb begin
    logic found;
    int   gsel;
    int   nxt;
    found         = 1'b0;
    gsel          = 0;
    win_group_p0  = '0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      gsel = int'(rr_ptr) + k;
      if (gsel >= NUM_GROUPS) gsel = gsel - NUM_GROUPS;
      if (!found && grp_any_p0[gsel]) begin
        found        = 1'b1;
        win_group_p0 = GW'(gsel);
      end
    end
    win_idx_p0    = IW'(int'(win_group_p0) * GROUP_SIZE + int'(grp_lidx_p0[win_group_p0]));
    win_onehot_p0 = '0;
    win_onehot_p0[win_idx_p0] = 1'b1;
    nxt = int'(win_group_p0) + 1;
    if (nxt >= NUM_GROUPS) nxt = 0;
    next_ptr_p0 = GW'(nxt);
  end

  // Decide whether the coming edge holds, regrants or goes idle.
  always_comb begin
    action_p0 = ACT_IDLE;
    if (hold_p0 && !expire_p0) begin
      action_p0 = ACT_HOLD;
    end else if (|req_eff_p0) begin
      action_p0 = ACT_GRANT;
    end
  end

  // ---- stage boundary: arbitration result into the grant register ----
  // Grant register and rr pointer; the pointer only moves on a new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_group <= '0;
      rr_ptr      <= '0;
    end else begin
      case (action_p0)
        ACT_GRANT: begin
          grant       <= win_onehot_p0;
          grant_valid <= 1'b1;
          grant_idx   <= win_idx_p0;
          grant_group <= win_group_p0;
          rr_ptr      <= next_ptr_p0;
        end
        ACT_IDLE: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_idx   <= '0;
          grant_group <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter: counts held cycles, saturates when nobody else waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (action_p0 == ACT_HOLD) begin
      if (hold_cnt != HW'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + HW'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_hier_rr_arbiter.sv
// Directed self-checking bench for hier_rr_arbiter at NUM_GROUPS=2,
// GROUP_SIZE=2. The timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_hier_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       grant_group;

  int tests_run = 0;
  int tests_failed = 0;

  hier_rr_arbiter #(
    .NUM_GROUPS (2),
    .GROUP_SIZE (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_group (grant_group)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed vector layout: {grant[3:0], valid, idx[1:0], group}
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0000, 1'b0, 2'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: got grant=%b v=%b idx=%0d grp=%0d, want 0000/0/0/0",
                 i, grant, grant_valid, grant_idx, grant_group);
      end
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: got grant=%b v=%b idx=%0d grp=%0d, want 0001/1/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
  endtask

  task automatic test_lock();
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL lock cyc%0d: got grant=%b v=%b idx=%0d grp=%0d, want 0001/1/0/0",
                 i, grant, grant_valid, grant_idx, grant_group);
      end
    end
  endtask

  task automatic test_handover();
    // Holder bit0 drops; pointer sits at group 1 -> bit2 wins, pointer to 0.
    req = 4'b1110;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0100, 1'b1, 2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL handover_g1: got grant=%b v=%b idx=%0d grp=%0d, want 0100/1/2/1",
               grant, grant_valid, grant_idx, grant_group);
    end
    // Holder bit2 drops; scan from group 0 finds bit1 first.
    req = 4'b1010;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0010, 1'b1, 2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL handover_g0: got grant=%b v=%b idx=%0d grp=%0d, want 0010/1/1/0",
               grant, grant_valid, grant_idx, grant_group);
    end
  endtask

  task automatic test_idle();
    req = 4'b0000;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0000, 1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL idle: got grant=%b v=%b idx=%0d grp=%0d, want 0000/0/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
    req = 4'b1000;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b1000, 1'b1, 2'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL idle_to_bit3: got grant=%b v=%b idx=%0d grp=%0d, want 1000/1/3/1",
               grant, grant_valid, grant_idx, grant_group);
    end
  endtask

  task automatic test_reset_mid_hold();
    // Pointer is 0 after granting group 1; group 0 empty so bit2 wins.
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0100, 1'b1, 2'd2, 1'b1}) begin
        tests_failed++;
        $display("FAIL midhold_pre cyc%0d: got grant=%b v=%b idx=%0d grp=%0d, want 0100/1/2/1",
                 i, grant, grant_valid, grant_idx, grant_group);
      end
    end
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0000, 1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midhold_rst: got grant=%b v=%b idx=%0d grp=%0d, want 0000/0/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midhold_after: got grant=%b v=%b idx=%0d grp=%0d, want 0001/1/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
    // Pointer is now 1; a reset must return it to 0 so bit0 wins again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL ptr_reset: got grant=%b v=%b idx=%0d grp=%0d, want 0001/1/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
  endtask

  task automatic test_back_to_back();
    // Holding bit0 with pointer 1. Drop bit0: bit2 wins, pointer to 0.
    req = 4'b0100;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0100, 1'b1, 2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_a: got grant=%b v=%b idx=%0d grp=%0d, want 0100/1/2/1",
               grant, grant_valid, grant_idx, grant_group);
    end
    // Re-raised bit0 must not steal the lock from bit2.
    req = 4'b0101;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0100, 1'b1, 2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_lock: got grant=%b v=%b idx=%0d grp=%0d, want 0100/1/2/1",
               grant, grant_valid, grant_idx, grant_group);
    end
    req = 4'b0001;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_b: got grant=%b v=%b idx=%0d grp=%0d, want 0001/1/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
    // Pointer 1 now: with bits 1 and 3 both new, group 1 ranks first.
    req = 4'b1010;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b1000, 1'b1, 2'd3, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_rr: got grant=%b v=%b idx=%0d grp=%0d, want 1000/1/3/1",
               grant, grant_valid, grant_idx, grant_group);
    end
    req = 4'b0000;
    tick();
    tests_run++;
    if ({grant, grant_valid, grant_idx, grant_group} !== {4'b0000, 1'b0, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_idle: got grant=%b v=%b idx=%0d grp=%0d, want 0000/0/0/0",
               grant, grant_valid, grant_idx, grant_group);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] exp_g;
    rst = 1'b1;
    req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      exp_g = (i >= 8 && i < 16) ? 4'b0100 : 4'b0001;
      tests_run++;
      if (grant !== exp_g) begin
        tests_failed++;
        $display("FAIL timeout_rot cyc%0d: got grant=%b, want %b", i, grant, exp_g);
      end
    end
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (grant !== 4'b0001) begin
        tests_failed++;
        $display("FAIL timeout_sole cyc%0d: got grant=%b, want 0001", i, grant);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_handover();
    test_idle();
    test_reset_mid_hold();
    test_back_to_back();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
